pe_ws_dbuf: RTL and testbench
=============================

// Module: pe_ws_dbuf
// PURPOSE
//  Weight-stationary systolic PE with a double-buffered weight register. A new
//  weight shifts down the column into a shadow register while the active weight
//  keeps computing; w_swap then promotes shadow to active without a stall.
//  Adds a valid-qualified activation path, signed/unsigned MAC, and a
//  saturating or wrapping accumulate with an overflow flag.
//  Instantiated N x M to form the array; the sum flows down, activations flow right.
// PARAMETERS
//  DATA_W  18        activation/weight width
//  ACC_W   2*DATA_W  partial-sum width; must be >= 2*DATA_W
//  SIGNED  1         1: two's-complement operands/sum; 0: unsigned
//  SAT_EN  1         1: clamp sum on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//  clk              in   1       clock, rising edge
//  rst_n            in   1       asynchronous active-low reset
//  w_load           in   1       shift weight chain: shadow <= in_weight_above
//  w_swap           in   1       promote shadow weight to active weight
//  in_weight_above  in   DATA_W  weight from the PE above
//  out_weight_below out  DATA_W  shadow register value, to the PE below
//  act_valid_in     in   1       active_left is valid this cycle
//  active_left      in   DATA_W  activation from the left
//  act_valid_out    out  1       registered act_valid_in
//  active_right     out  DATA_W  registered active_left, to the right
//  in_sum           in   ACC_W   partial sum from above
//  out_sum          out  ACC_W   registered partial sum, to below
//  sum_ovf          out  1       out_sum overflowed this cycle (registered with out_sum)
//  ovf_sticky       out  1       OR of all sum_ovf since reset/clr_ovf
//  clr_ovf          in   1       synchronous clear of ovf_sticky
//  w_pending        out  1       shadow loaded but not yet swapped
// BEHAVIOUR
//  - Reset (async, rst_n=0): shadow, active weight, out_weight_below,
//    active_right, act_valid_out, out_sum, sum_ovf, ovf_sticky and w_pending = 0.
//    Asserting reset mid-stream discards all in-flight data; the first edge
//    after release behaves as a fresh cycle.
//  - Weight chain: out_weight_below = shadow_q (no extra stage). With w_load
//    held across a column of K PEs, the first weight fed reaches the bottom PE
//    after K edges. With w_load=0, shadow holds.
//  - Swap: at the edge where w_swap=1, active <= shadow_q (pre-edge value).
//    If w_load and w_swap are both 1, active gets the OLD shadow and shadow
//    gets in_weight_above.
//    A MAC in the swap cycle uses the old active weight; the new weight is used
//    from the next cycle on.
//  - w_pending: set by w_load, cleared by w_swap. If both are 1, w_pending stays 1.
//  - Activation path: 1-cycle latency. active_right <= active_left;
//    act_valid_out <= act_valid_in. Data is forwarded even when the valid bit is 0.
//  - MAC: 1-cycle latency.
//    - If act_valid_in=1: out_sum <= in_sum + active_left*active_w.
//    - Else: out_sum <= in_sum, and sum_ovf <= 0 (bubble passes untouched).
//    - Product is a full 2*DATA_W product, sign-extended (SIGNED=1) or
//      zero-extended (SIGNED=0) to ACC_W+1. The sum is computed in ACC_W+1 bits.
//  - Overflow:
//    - SIGNED=1: the operand signs are equal and the result sign differs.
//    - SIGNED=0: carry out of bit ACC_W-1.
//    - On overflow, sum_ovf=1 regardless of SAT_EN.
//    - SAT_EN=1 clamps to +max/-min (signed) or all-ones (unsigned).
//    - SAT_EN=0 keeps the low ACC_W bits.
//  - ovf_sticky <= clr_ovf ? 0 : ovf_sticky | next sum_ovf.
//    If clr_ovf=1 and an overflow occur in the same cycle, clear wins.
// TESTING (DATA_W=18, ACC_W=36, SIGNED=1 unless noted)
//  1. Reset, then w_load=1 in_weight_above=5 for one cycle, then w_swap=1.
//     Next cycle act_valid_in=1, active_left=3, in_sum=10 -> out_sum=25 one
//     cycle later; w_pending goes 1 then 0.
//  2. Active=5; load 7 into shadow; stream active_left=2, in_sum=0 -> out_sum=10
//     until the swap cycle inclusive, 14 thereafter; no bubble in act_valid_out.
//  3. w_load=1 w_swap=1 together with shadow=4 and in_weight_above=9
//     -> active=4, out_weight_below=9, w_pending=1.
//  4. act_valid_in=0, active_left=100, in_sum=123 -> out_sum=123,
//     active_right=100, act_valid_out=0, sum_ovf=0.
//  5. in_sum=0x7_FFFF_FFFF, active_left=1, weight=1:
//     - SAT_EN=1 -> out_sum=0x7_FFFF_FFFF, sum_ovf=1, ovf_sticky=1.
//     - SAT_EN=0 -> out_sum=0x8_0000_0000.
//     - A following cycle with clr_ovf=1 and no overflow -> ovf_sticky=0.
//  6. Drop rst_n mid-stream between clock edges -> all outputs read 0
//     immediately; after release, test 1 passes again.

Source files
------------

// File: rtl/pe_ws_dbuf.sv
// rtl/pe_ws_dbuf.sv - weight-stationary systolic PE with double-buffered weight
// Shadow weight shifts down the column while the active weight keeps computing.
module pe_ws_dbuf #(
  parameter int DATA_W = 18,
  parameter int ACC_W  = 2 * DATA_W,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_load,
  input  logic              w_swap,
  input  logic [DATA_W-1:0] in_weight_above,
  output logic [DATA_W-1:0] out_weight_below,
  input  logic              act_valid_in,
  input  logic [DATA_W-1:0] active_left,
  output logic              act_valid_out,
  output logic [DATA_W-1:0] active_right,
  input  logic [ACC_W-1:0]  in_sum,
  output logic [ACC_W-1:0]  out_sum,
  output logic              sum_ovf,
  output logic              ovf_sticky,
  input  logic              clr_ovf,
  output logic              w_pending
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] active_w;
  logic [PW-1:0]     act_x;
  logic [PW-1:0]     wgt_x;
  logic [PW-1:0]     prod;
  logic [ACC_W:0]    prod_x;
  logic [ACC_W:0]    in_sum_x;
  logic [ACC_W:0]    sum_x;
  logic              ovf;
  logic [ACC_W-1:0]  sat_val;
  logic [ACC_W-1:0]  sum_next;
  logic              ovf_next;

  assign out_weight_below = shadow_q;

  always_comb begin
    act_x    = '0;
    wgt_x    = '0;
    prod_x   = '0;
    in_sum_x = '0;
    sat_val  = '1;
    ovf      = 1'b0;
    if (SIGNED) begin
      act_x    = {{DATA_W{active_left[DATA_W-1]}}, active_left};
      wgt_x    = {{DATA_W{active_w[DATA_W-1]}}, active_w};
    end else begin
      act_x    = {{DATA_W{1'b0}}, active_left};
      wgt_x    = {{DATA_W{1'b0}}, active_w};
    end
    // Low 2*DATA_W bits of the widened product equal the exact full product.
    prod = act_x * wgt_x;
    if (SIGNED) begin
      prod_x   = {{(ACC_W+1-PW){prod[PW-1]}}, prod};
      in_sum_x = {in_sum[ACC_W-1], in_sum};
    end else begin
      prod_x   = {{(ACC_W+1-PW){1'b0}}, prod};
      in_sum_x = {1'b0, in_sum};
    end
    sum_x = in_sum_x + prod_x;
    if (SIGNED) begin
      ovf     = (in_sum[ACC_W-1] == prod_x[ACC_W-1]) && (sum_x[ACC_W-1] != in_sum[ACC_W-1]);
      sat_val = in_sum[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf     = sum_x[ACC_W];
      sat_val = '1;
    end
    sum_next = in_sum;
    ovf_next = 1'b0;
    if (act_valid_in) begin
      ovf_next = ovf;
      sum_next = (ovf && SAT_EN) ? sat_val : sum_x[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      active_w      <= '0;
      w_pending     <= 1'b0;
      active_right  <= '0;
      act_valid_out <= 1'b0;
      out_sum       <= '0;
      sum_ovf       <= 1'b0;
      ovf_sticky    <= 1'b0;
    end else begin
      if (w_load) shadow_q <= in_weight_above;
      if (w_swap) active_w <= shadow_q;
      if (w_load)      w_pending <= 1'b1;
      else if (w_swap) w_pending <= 1'b0;
      active_right  <= active_left;
      act_valid_out <= act_valid_in;
      out_sum       <= sum_next;
      sum_ovf       <= ovf_next;
      ovf_sticky    <= clr_ovf ? 1'b0 : (ovf_sticky | ovf_next);
    end
  end

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// tb/tb_pe_ws_dbuf.sv - directed self-checking bench for pe_ws_dbuf
// Two instances share stimulus: saturating (s_) and wrapping (w_) accumulate.
module tb_pe_ws_dbuf;

  localparam int DATA_W = 18;
  localparam int ACC_W  = 36;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              w_load = 1'b0;
  logic              w_swap = 1'b0;
  logic [DATA_W-1:0] in_weight_above = '0;
  logic              act_valid_in = 1'b0;
  logic [DATA_W-1:0] active_left = '0;
  logic [ACC_W-1:0]  in_sum = '0;
  logic              clr_ovf = 1'b0;

  logic [DATA_W-1:0] s_wb, w_wb, s_ar, w_ar;
  logic              s_avo, w_avo, s_ovf, w_ovf, s_stk, w_stk, s_pend, w_pend;
  logic [ACC_W-1:0]  s_sum, w_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_ws_dbuf #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(1'b1), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_swap(w_swap),
    .in_weight_above(in_weight_above), .out_weight_below(s_wb),
    .act_valid_in(act_valid_in), .active_left(active_left),
    .act_valid_out(s_avo), .active_right(s_ar),
    .in_sum(in_sum), .out_sum(s_sum), .sum_ovf(s_ovf), .ovf_sticky(s_stk),
    .clr_ovf(clr_ovf), .w_pending(s_pend)
  );

  pe_ws_dbuf #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(1'b1), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_swap(w_swap),
    .in_weight_above(in_weight_above), .out_weight_below(w_wb),
    .act_valid_in(act_valid_in), .active_left(active_left),
    .act_valid_out(w_avo), .active_right(w_ar),
    .in_sum(in_sum), .out_sum(w_sum), .sum_ovf(w_ovf), .ovf_sticky(w_stk),
    .clr_ovf(clr_ovf), .w_pending(w_pend)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    w_load = 1'b0; w_swap = 1'b0; in_weight_above = '0;
    act_valid_in = 1'b0; active_left = '0; in_sum = '0; clr_ovf = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".wb"},   64'(s_wb), 64'd0);
    check({tag, ".ar"},   64'(s_ar), 64'd0);
    check({tag, ".avo"},  64'(s_avo), 64'd0);
    check({tag, ".sum"},  64'(s_sum), 64'd0);
    check({tag, ".ovf"},  64'(s_ovf), 64'd0);
    check({tag, ".stk"},  64'(s_stk), 64'd0);
    check({tag, ".pend"}, 64'(s_pend), 64'd0);
    check({tag, ".wsum"}, 64'(w_sum), 64'd0);
  endtask

  task automatic test_basic(input string tag);
    w_load = 1'b1; in_weight_above = 18'd5;
    step();
    check({tag, ".wb5"},   64'(s_wb), 64'd5);
    check({tag, ".pend1"}, 64'(s_pend), 64'd1);
    w_load = 1'b0; in_weight_above = '0; w_swap = 1'b1;
    step();
    check({tag, ".pend0"}, 64'(s_pend), 64'd0);
    w_swap = 1'b0; act_valid_in = 1'b1; active_left = 18'd3; in_sum = 36'd10;
    step();
    check({tag, ".sum25"}, 64'(s_sum), 64'd25);
    check({tag, ".avo"},   64'(s_avo), 64'd1);
    check({tag, ".ar3"},   64'(s_ar), 64'd3);
    check({tag, ".ovf0"},  64'(s_ovf), 64'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;

    test_basic("t1");

    // Active = 5, load 7 while streaming; swap uses old weight in its own cycle
    w_load = 1'b1; in_weight_above = 18'd7; active_left = 18'd2; in_sum = '0;
    step();
    check("t2.pre0", 64'(s_sum), 64'd10);
    check("t2.pend", 64'(s_pend), 64'd1);
    w_load = 1'b0;
    step();
    check("t2.pre1", 64'(s_sum), 64'd10);
    w_swap = 1'b1;
    step();
    check("t2.swapcyc", 64'(s_sum), 64'd10);
    check("t2.pend0", 64'(s_pend), 64'd0);
    w_swap = 1'b0;
    step();
    check("t2.post", 64'(s_sum), 64'd14);
    check("t2.avo", 64'(s_avo), 64'd1);

    // Simultaneous load and swap
    act_valid_in = 1'b0;
    w_load = 1'b1; in_weight_above = 18'd4;
    step();
    w_swap = 1'b1; in_weight_above = 18'd9;
    step();
    check("t3.wb9", 64'(s_wb), 64'd9);
    check("t3.pend", 64'(s_pend), 64'd1);
    w_load = 1'b0; w_swap = 1'b0;
    act_valid_in = 1'b1; active_left = 18'd3; in_sum = '0;
    step();
    check("t3.act4", 64'(s_sum), 64'd12);
    active_left = 18'h3FFFE;
    step();
    check("t3.neg", 64'(s_sum), 64'hF_FFFF_FFF8);

    // Bubble passes untouched
    act_valid_in = 1'b0; active_left = 18'd100; in_sum = 36'd123;
    step();
    check("t4.sum", 64'(s_sum), 64'd123);
    check("t4.ar", 64'(s_ar), 64'd100);
    check("t4.avo", 64'(s_avo), 64'd0);
    check("t4.ovf", 64'(s_ovf), 64'd0);

    // Overflow: weight 1
    w_load = 1'b1; in_weight_above = 18'd1;
    step();
    w_load = 1'b0; w_swap = 1'b1;
    step();
    w_swap = 1'b0; act_valid_in = 1'b1; active_left = 18'd1; in_sum = 36'h7_FFFF_FFFF;
    step();
    check("t5.ssum", 64'(s_sum), 64'h7_FFFF_FFFF);
    check("t5.sovf", 64'(s_ovf), 64'd1);
    check("t5.sstk", 64'(s_stk), 64'd1);
    check("t5.wsum", 64'(w_sum), 64'h8_0000_0000);
    check("t5.wovf", 64'(w_ovf), 64'd1);
    clr_ovf = 1'b1; in_sum = '0;
    step();
    check("t5.clr", 64'(s_stk), 64'd0);
    check("t5.clrsum", 64'(s_sum), 64'd1);
    check("t5.clrovf", 64'(s_ovf), 64'd0);
    clr_ovf = 1'b0; active_left = 18'h3FFFF; in_sum = 36'h8_0000_0000;
    step();
    check("t5.nsat", 64'(s_sum), 64'h8_0000_0000);
    check("t5.nwrap", 64'(w_sum), 64'h7_FFFF_FFFF);
    check("t5.novf", 64'(s_ovf), 64'd1);
    check("t5.nstk", 64'(w_stk), 64'd1);
    clr_ovf = 1'b1; in_sum = 36'h7_FFFF_FFFF; active_left = 18'd1;
    step();
    check("t5.clrwin", 64'(s_stk), 64'd0);
    check("t5.clrwinovf", 64'(s_ovf), 64'd1);

    // Asynchronous reset mid-stream
    clr_ovf = 1'b0; w_load = 1'b1; in_weight_above = 18'd11; in_sum = 36'd50;
    step();
    #2 rst_n = 1'b0;
    #1 check_zero("t6");
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic("t6r");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
